// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and stall controller for the five-stage BU2020 pipeline.
// Decides each cycle whether the PC and the IF_ID/ID_EX/EX_MEM/MEM_WB registers
// load, hold or take a bubble. It handles load-use hazards, taken branches
// resolved in MEM, and multi-cycle data-memory accesses with a timeout watchdog.
// It also keeps saturating stall and flush counters.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_rs1/id_rs2            ID source registers, qualified by id_use_rs1/2
//   ex_rd, ex_memread        EX destination register and load flag
//   mem_branch_taken         taken branch sitting in MEM
//   mem_req, mem_ready       data-memory access request / completion
//   pc_write, pc_sel_branch  PC load enable and branch-target select
//   *_en, *_flush            stage register load enables and bubble inserts
//   mem_timeout              sticky: an access was force-released
//   stall_count, flush_count saturating performance counters
// Control outputs are combinational from the state and the inputs in the same cycle.
module pipeline_ctrl #(
    parameter int unsigned REG_AW      = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              mem_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              pc_sel_branch,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mem_timeout,
    output logic [15:0]       stall_count,
    output logic [15:0]       flush_count
);

    localparam int unsigned WAIT_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              freeze, timeout_set, branch_flush, lu_stall, hazard;

    // Load-use match between the ID sources and the load in EX.
    assign hazard = ex_memread &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

    // State register, sticky timeout flag and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
            if ((freeze || lu_stall) && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (branch_flush && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

    // Next state, freeze decision and stage-control outputs.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        freeze        = 1'b0;
        timeout_set   = 1'b0;
        branch_flush  = 1'b0;
        lu_stall      = 1'b0;
        pc_write      = 1'b1;
        pc_sel_branch = 1'b0;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze     = 1'b1;
                    state_d    = MWAIT;
                    wait_cnt_d = '0;
                end
            end
            MWAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Watchdog expiry: release as though the memory answered.
                    state_d     = RUN;
                    timeout_set = 1'b1;
                end else begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: state_d = RUN;
        endcase

        if (rst) begin
            // Load bubbles everywhere while the PC is held.
            freeze       = 1'b0;
            timeout_set  = 1'b0;
            pc_write     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (freeze) begin
            pc_write  = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (mem_branch_taken) begin
            branch_flush  = 1'b1;
            pc_sel_branch = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
        end else if (hazard) begin
            // Hold IF/ID one cycle and push a bubble into ID_EX.
            lu_stall    = 1'b1;
            pc_write    = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_pipeline_ctrl;

    localparam int unsigned REG_AW = 4;
    localparam int unsigned MT     = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
    logic              id_use_rs1, id_use_rs2, ex_memread;
    logic              mem_branch_taken, mem_req, mem_ready;
    logic              pc_write, pc_sel_branch;
    logic              if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic              if_id_flush, id_ex_flush, ex_mem_flush;
    logic              mem_timeout;
    logic [15:0]       stall_count, flush_count;

    pipeline_ctrl #(.REG_AW(REG_AW), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread),
        .mem_branch_taken(mem_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_sel_branch(pc_sel_branch),
        .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush),
        .mem_timeout(mem_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: frozen cycles spent on the pending access, not a state machine copy.
    bit m_valid   = 1'b0;
    bit m_in_wait = 1'b0;
    int m_fcount  = 0;
    bit m_timeout = 1'b0;
    int m_stall   = 0;
    int m_flush   = 0;

    // Per-cycle model decisions, computed in settle() and consumed in tick().
    bit e_frz, e_forced, e_bf, e_lu;

    // {pc_write, pc_sel_branch, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl, ex_mem_fl}
    function automatic logic [8:0] ctl_vec();
        return {pc_write, pc_sel_branch, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Evaluate the model for the current inputs and compare every output.
    task automatic settle();
        bit hz;
        logic [8:0] exp_v;
        #1;
        hz = ex_memread && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        e_frz    = !rst && !mem_ready && (m_in_wait ? (m_fcount < MT) : mem_req);
        e_forced = !rst && m_in_wait && !mem_ready && (m_fcount == MT);
        e_bf     = !rst && !e_frz && mem_branch_taken;
        e_lu     = !rst && !e_frz && !e_bf && hz;
        if (rst)        exp_v = 9'b0_0_1111_111;
        else if (e_frz) exp_v = 9'b0_0_0000_000;
        else if (e_bf)  exp_v = 9'b1_1_1111_111;
        else if (e_lu)  exp_v = 9'b0_0_0111_010;
        else            exp_v = 9'b1_0_1111_000;
        chk("ctl", 32'(ctl_vec()), 32'(exp_v));
        if (m_valid) begin
            chk("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
            chk("stall_count", 32'(stall_count), 32'(m_stall));
            chk("flush_count", 32'(flush_count), 32'(m_flush));
        end
    endtask

    // Advance one clock and update the model with this cycle's decisions.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b1; m_in_wait = 1'b0; m_fcount = 0;
            m_timeout = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if ((e_frz || e_lu) && m_stall < 65535) m_stall++;
            if (e_bf && m_flush < 65535) m_flush++;
            if (e_forced) m_timeout = 1'b1;
            if (e_frz) begin m_in_wait = 1'b1; m_fcount++; end
            else begin m_in_wait = 1'b0; m_fcount = 0; end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
        mem_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        settle();
        chk("rst_ctl", 32'(ctl_vec()), 32'(9'b0_0_1111_111));
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        @(negedge clk);

        // Reset state
        do_reset();
        chk("rst_stall", 32'(stall_count), 32'd0);
        chk("rst_flush", 32'(flush_count), 32'd0);
        chk("rst_tmo",   32'(mem_timeout), 32'd0);

        // Load-use stall
        ex_memread = 1'b1; ex_rd = 4'd5; id_rs2 = 4'd5; id_use_rs2 = 1'b1;
        settle();
        chk("lu_ctl", 32'(ctl_vec()), 32'(9'b0_0_0111_010));
        tick();
        chk("lu_stall", 32'(stall_count), 32'd1);

        // No false hazard when the matching source is unused
        id_use_rs2 = 1'b0; id_rs1 = 4'd5; id_use_rs1 = 1'b0;
        settle();
        chk("nohz_ctl", 32'(ctl_vec()), 32'(9'b1_0_1111_000));
        tick();
        chk("nohz_stall", 32'(stall_count), 32'd1);

        // Branch overrides a simultaneous load-use match
        do_reset();
        ex_memread = 1'b1; ex_rd = 4'd5; id_rs2 = 4'd5; id_use_rs2 = 1'b1;
        mem_branch_taken = 1'b1;
        settle();
        chk("br_ctl", 32'(ctl_vec()), 32'(9'b1_1_1111_111));
        tick();
        chk("br_flush", 32'(flush_count), 32'd1);
        chk("br_stall", 32'(stall_count), 32'd0);

        // Memory wait: three frozen cycles, release on the fourth
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("mw_frozen", 32'(ctl_vec()), 32'(9'b0));
            tick();
        end
        mem_ready = 1'b1;
        settle();
        chk("mw_release", 32'(ctl_vec()), 32'(9'b1_0_1111_000));
        tick();
        chk("mw_stall", 32'(stall_count), 32'd3);
        mem_req = 1'b0; mem_ready = 1'b0;
        settle();
        chk("mw_run", 32'(ctl_vec()), 32'(9'b1_0_1111_000));
        tick();

        // Timeout: MT frozen cycles, one release cycle, flag visible afterwards
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int c = 0; c < int'(MT); c++) begin
            settle();
            chk("to_frozen", 32'(pc_write), 32'd0);
            tick();
        end
        settle();
        chk("to_release", 32'(ctl_vec()), 32'(9'b1_0_1111_000));
        chk("to_flag_late", 32'(mem_timeout), 32'd0);
        tick();
        settle();
        chk("to_flag", 32'(mem_timeout), 32'd1);
        chk("to_stall", 32'(stall_count), 32'(MT));
        tick();

        // Reset in frozen cycle 2 of a fresh access returns to RUN cleanly
        rst = 1'b1;
        settle();
        tick();
        rst = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        settle();
        chk("rstw_run", 32'(ctl_vec()), 32'(9'b1_0_1111_000));
        chk("rstw_tmo", 32'(mem_timeout), 32'd0);
        chk("rstw_stall", 32'(stall_count), 32'd0);
        tick();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst              = ($urandom_range(0, 99) == 0);
            id_rs1           = REG_AW'($urandom_range(0, 3));
            id_rs2           = REG_AW'($urandom_range(0, 3));
            ex_rd            = REG_AW'($urandom_range(0, 3));
            id_use_rs1       = 1'($urandom);
            id_use_rs2       = 1'($urandom);
            ex_memread       = 1'($urandom);
            mem_branch_taken = ($urandom_range(0, 5) == 0);
            mem_req          = ($urandom_range(0, 3) == 0);
            mem_ready        = ($urandom_range(0, 4) == 0);
            settle();
            tick();
        end

        // Saturation: a held load-use match stalls every cycle
        do_reset();
        ex_memread = 1'b1; ex_rd = 4'd7; id_rs1 = 4'd7; id_use_rs1 = 1'b1;
        for (int c = 0; c < 65537; c++) begin
            settle();
            tick();
        end
        chk("sat_stall", 32'(stall_count), 32'h0000_FFFF);
        idle();
        settle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
